tetris_cell_locator: RTL

Upstream stage of the tetris renderer. It converts raw video-timing pixel coordinates into the 4-bit board cell indices (cell x, cell y) that the renderer uses to look up its cell colour map. It also produces the once-per-frame new-frame pulse that the renderer's game tick runs from. It sits between the HDMI video timing generator and the renderer, in the pixel clock domain. Cell position is tracked with sub-cell counters; no dividers are used.

---
 rtl/tetris_cell_locator.sv | 130 +++++++++++++
 1 files changed

// File: rtl/tetris_cell_locator.sv
// Converts video-timing pixel coordinates into board cell indices using sub-cell
// counters (no dividers), and emits a one-cycle pulse on the first pixel of a frame.
module tetris_cell_locator #(
  parameter int CW       = 12,
  parameter int BOARD_X0 = 160,
  parameter int BOARD_Y0 = 0,
  parameter int CELL_W   = 30,
  parameter int CELL_H   = 30,
  parameter int COLS     = 10,
  parameter int ROWS     = 16
) (
  input  logic          i_pixclk,
  input  logic          i_rst_n,
  input  logic          i_active,
  input  logic [CW-1:0] i_x,
  input  logic [CW-1:0] i_y,
  output logic [3:0]    o_cell_x,
  output logic [3:0]    o_cell_y,
  output logic          o_in_board,
  output logic          o_grid,
  output logic          o_newframe,
  output logic          o_valid
);

  localparam int SXW = $clog2(CELL_W);
  localparam int SYW = $clog2(CELL_H);
  localparam int CLW = $clog2(COLS + 1);
  localparam int RWW = $clog2(ROWS + 1);

  localparam logic [SXW-1:0] SUBX_LAST = SXW'(CELL_W - 1);
  localparam logic [SYW-1:0] SUBY_LAST = SYW'(CELL_H - 1);
  localparam logic [CLW-1:0] COL_END   = CLW'(COLS);
  localparam logic [RWW-1:0] ROW_END   = RWW'(ROWS);

  logic [SXW-1:0] sub_x, sub_x_n;
  logic [SYW-1:0] sub_y, sub_y_n;
  logic [CLW-1:0] col,   col_n;
  logic [RWW-1:0] row,   row_n;
  logic           sync,  sync_n;

  logic at_x0, at_y0, x_ge, y_ge;
  logic in_board_n, newframe_n;

  assign at_x0 = (i_x == CW'(BOARD_X0));
  assign at_y0 = (i_y == CW'(BOARD_Y0));

  // A zero origin makes the lower-bound compare trivially true; skip it outright.
  if (BOARD_X0 == 0) begin : g_x_ge_const
    assign x_ge = 1'b1;
  end else begin : g_x_ge_cmp
    assign x_ge = (i_x >= CW'(BOARD_X0));
  end

  if (BOARD_Y0 == 0) begin : g_y_ge_const
    assign y_ge = 1'b1;
  end else begin : g_y_ge_cmp
    assign y_ge = (i_y >= CW'(BOARD_Y0));
  end

  always_comb begin
    sub_x_n = sub_x;
    col_n   = col;
    sub_y_n = sub_y;
    row_n   = row;
    sync_n  = sync;
    if (i_active) begin
      if (at_x0) begin
        sub_x_n = '0;
        col_n   = '0;
      end else if (col < COL_END) begin
        if (sub_x == SUBX_LAST) begin
          sub_x_n = '0;
          col_n   = col + CLW'(1);
        end else begin
          sub_x_n = sub_x + SXW'(1);
        end
      end

      // Rows advance once per line, at the board's left edge.
      if (at_x0) begin
        if (at_y0) begin
          sub_y_n = '0;
          row_n   = '0;
          sync_n  = 1'b1;
        end else if (sync && (row < ROW_END)) begin
          if (sub_y == SUBY_LAST) begin
            sub_y_n = '0;
            row_n   = row + RWW'(1);
          end else begin
            sub_y_n = sub_y + SYW'(1);
          end
        end
      end
    end
  end

  always_comb begin
    in_board_n = i_active & sync_n & x_ge & y_ge & (col_n < COL_END) & (row_n < ROW_END);
    newframe_n = i_active & (i_x == '0) & (i_y == '0);
  end

  always_ff @(posedge i_pixclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sub_x      <= '0;
      col        <= '0;
      sub_y      <= '0;
      row        <= '0;
      sync       <= 1'b0;
      o_cell_x   <= '0;
      o_cell_y   <= '0;
      o_in_board <= 1'b0;
      o_grid     <= 1'b0;
      o_newframe <= 1'b0;
      o_valid    <= 1'b0;
    end else begin
      sub_x      <= sub_x_n;
      col        <= col_n;
      sub_y      <= sub_y_n;
      row        <= row_n;
      sync       <= sync_n;
      o_valid    <= i_active;
      o_newframe <= newframe_n;
      o_in_board <= in_board_n;
      o_cell_x   <= in_board_n ? 4'(col_n) : '0;
      o_cell_y   <= in_board_n ? 4'(row_n) : '0;
      o_grid     <= in_board_n & ((sub_x_n == '0) | (sub_y_n == '0));
    end
  end

endmodule
